rhythm_lane_engine: RTL

- Parametrised note-highway game core.
- Scrolls note rows toward a hit line, judges per-lane key presses, keeps score, combo, high score and countdown, and sequences IDLE/PLAY/OVER.
- Sits between the LFSR/speed-select logic (supplies `spawn`, `step`, `tick_1s`) and the LED-matrix driver and hex decoders.
- Adds over the previous generation:
  - edge-qualified presses
  - saturating arithmetic
  - combo tracking
  - explicit game states

---
 rtl/rhythm_lane_engine_pkg.sv | 36 +++
 rtl/rhythm_lane_engine_if.sv | 32 +++
 rtl/rhythm_lane_engine_lane_judge.sv | 45 ++++
 rtl/rhythm_lane_engine.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/rhythm_lane_engine_pkg.sv
// Shared types and saturating helpers for the rhythm lane engine.
package rhythm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } game_state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        HIT  = 2'd1,
        NEAR = 2'd2,
        MISS = 2'd3
    } judge_t;

    // Add two counts, clamping at the largest value a width-bit register holds.
    function automatic int unsigned satAdd(input int unsigned a, input int unsigned b,
                                           input int unsigned width);
        int unsigned maxVal;
        maxVal = (32'd1 << width) - 32'd1;
        if ((a >= maxVal) || (b >= (maxVal - a))) begin
            return maxVal;
        end
        return a + b;
    endfunction

    // Subtract b from a, clamping at zero.
    function automatic int unsigned satSub(input int unsigned a, input int unsigned b);
        if (b >= a) begin
            return 32'd0;
        end
        return a - b;
    endfunction

endpackage

// File: rtl/rhythm_lane_engine_if.sv
// Game-side bus: strobes and keys toward the engine, display data back out.
interface rhythm_lane_engine_if #(
    parameter int NUM_LANES = 4,
    parameter int ROWS      = 16,
    parameter int LANE_W    = 4,
    parameter int SCORE_W   = 9,
    parameter int TIME_W    = 5
);
    logic                                    step;
    logic                                    tick_1s;
    logic                                    start;
    logic                                    clear_high;
    logic [NUM_LANES-1:0]                    key_n;
    logic [NUM_LANES-1:0]                    spawn;
    logic [ROWS-1:0][NUM_LANES*LANE_W-1:0]   red_pixels;
    logic [ROWS-1:0][NUM_LANES*LANE_W-1:0]   grn_pixels;
    logic [SCORE_W-1:0]                      score;
    logic [SCORE_W-1:0]                      high_score;
    logic [SCORE_W-1:0]                      combo;
    logic [TIME_W-1:0]                       time_left;
    logic [1:0]                              game_state;

    modport master (
        output step, tick_1s, start, clear_high, key_n, spawn,
        input  red_pixels, grn_pixels, score, high_score, combo, time_left, game_state
    );

    modport slave (
        input  step, tick_1s, start, clear_high, key_n, spawn,
        output red_pixels, grn_pixels, score, high_score, combo, time_left, game_state
    );
endinterface

// File: rtl/rhythm_lane_engine_lane_judge.sv
// Per-lane key edge detection and hit/near/miss classification.
module lane_judge
    import rhythm_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   keyN_i,
    input  logic   playing_i,
    input  logic   row0_i,
    input  logic   row1_i,
    output judge_t judge_o,
    output logic   clrRow0_o,
    output logic   clrRow1_o
);
    logic keyPrev_q;
    logic press;

    // Remember the previous key level so only a fresh press is judged.
    always_ff @(posedge clk) begin
        if (reset) begin
            keyPrev_q <= 1'b1;
        end else begin
            keyPrev_q <= keyN_i;
        end
    end

    // Classify a fresh press against the two rows nearest the hit line.
    always_comb begin
        press     = keyPrev_q & ~keyN_i;
        judge_o   = NONE;
        clrRow0_o = 1'b0;
        clrRow1_o = 1'b0;
        if (playing_i && press) begin
            if (row0_i) begin
                judge_o   = HIT;
                clrRow0_o = 1'b1;
            end else if (row1_i) begin
                judge_o   = NEAR;
                clrRow1_o = 1'b1;
            end else begin
                judge_o   = MISS;
            end
        end
    end
endmodule

// File: rtl/rhythm_lane_engine.sv
// Note-highway game core: scrolling notes, judging, scoring, timer and state.
module rhythm_lane_engine
    import rhythm_pkg::*;
#(
    parameter int NUM_LANES    = 4,
    parameter int ROWS         = 16,
    parameter int LANE_W       = 4,
    parameter int SCORE_W      = 9,
    parameter int TIME_W       = 5,
    parameter int GAME_SECONDS = 30,
    parameter int HIT_PTS      = 2,
    parameter int NEAR_PTS     = 1,
    parameter int MISS_PTS     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    rhythm_lane_engine_if.slave  bus
);
    localparam int COLS = NUM_LANES * LANE_W;

    game_state_t                         state_q;
    logic [ROWS-1:0][NUM_LANES-1:0]      noteStore_q;
    logic [ROWS-1:0][NUM_LANES-1:0]      noteStore_d;
    logic [ROWS-1:0][NUM_LANES-1:0]      storeCleared;
    logic [SCORE_W-1:0]                  score_q;
    logic [SCORE_W-1:0]                  score_d;
    logic [SCORE_W-1:0]                  combo_q;
    logic [SCORE_W-1:0]                  combo_d;
    logic [SCORE_W-1:0]                  highScore_q;
    logic [TIME_W-1:0]                   timeLeft_q;
    logic                                startPrev_q;
    logic                                startRise;
    logic [ROWS-1:0][COLS-1:0]           redPix_q;
    logic [ROWS-1:0][COLS-1:0]           redPix_d;
    logic [ROWS-1:0][COLS-1:0]           grnPix_q;
    logic [ROWS-1:0][COLS-1:0]           grnPix_d;

    judge_t                              laneJudge [NUM_LANES];
    logic [NUM_LANES-1:0]                clrRow0;
    logic [NUM_LANES-1:0]                clrRow1;
    logic                                playing;
    logic                                exitMiss;
    logic                                anyMiss;
    int unsigned                         posPts;
    int unsigned                         negPts;
    int unsigned                         hitCount;

    assign playing   = (state_q == PLAY);
    assign startRise = bus.start & ~startPrev_q;

    for (genvar g = 0; g < NUM_LANES; g++) begin : gLane
        lane_judge uJudge (
            .clk       (clk),
            .reset     (reset),
            .keyN_i    (bus.key_n[g]),
            .playing_i (playing),
            .row0_i    (noteStore_q[0][g]),
            .row1_i    (noteStore_q[1][g]),
            .judge_o   (laneJudge[g]),
            .clrRow0_o (clrRow0[g]),
            .clrRow1_o (clrRow1[g])
        );
    end

    // Sum lane results, then derive the next note store, score and combo.
    always_comb begin
        posPts   = 0;
        negPts   = 0;
        hitCount = 0;
        anyMiss  = 1'b0;
        for (int l = 0; l < NUM_LANES; l++) begin
            case (laneJudge[l])
                HIT: begin
                    posPts   = posPts + HIT_PTS;
                    hitCount = hitCount + 1;
                end
                NEAR: begin
                    posPts   = posPts + NEAR_PTS;
                    hitCount = hitCount + 1;
                end
                MISS: begin
                    negPts  = negPts + MISS_PTS;
                    anyMiss = 1'b1;
                end
                default: ;
            endcase
        end

        storeCleared    = noteStore_q;
        storeCleared[0] = noteStore_q[0] & ~clrRow0;
        storeCleared[1] = noteStore_q[1] & ~clrRow1;

        noteStore_d = storeCleared;
        if (bus.step) begin
            for (int i = 0; i < ROWS - 1; i++) begin
                noteStore_d[i] = storeCleared[i+1];
            end
            noteStore_d[ROWS-1] = bus.spawn;
        end

        exitMiss = bus.step && playing && (|storeCleared[0]);

        if (posPts >= negPts) begin
            score_d = SCORE_W'(satAdd(32'(score_q), posPts - negPts, SCORE_W));
        end else begin
            score_d = SCORE_W'(satSub(32'(score_q), negPts - posPts));
        end

        if (anyMiss || exitMiss) begin
            combo_d = '0;
        end else if (hitCount != 0) begin
            combo_d = SCORE_W'(satAdd(32'(combo_q), hitCount, SCORE_W));
        end else begin
            combo_d = combo_q;
        end
    end

    // Paint notes in lane colours and, while playing, held keys as yellow on row 0.
    always_comb begin
        redPix_d = '0;
        grnPix_d = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                for (int c = 0; c < LANE_W; c++) begin
                    if (noteStore_q[r][l]) begin
                        if ((l % 2) == 0) begin
                            redPix_d[r][l*LANE_W + c] = 1'b1;
                        end else begin
                            grnPix_d[r][l*LANE_W + c] = 1'b1;
                        end
                    end
                end
            end
        end
        if (playing) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (!bus.key_n[l]) begin
                    for (int c = 0; c < LANE_W; c++) begin
                        redPix_d[0][l*LANE_W + c] = 1'b1;
                        grnPix_d[0][l*LANE_W + c] = 1'b1;
                    end
                end
            end
        end
    end

    // Game state machine together with every register it governs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            noteStore_q <= '0;
            score_q     <= '0;
            combo_q     <= '0;
            highScore_q <= '0;
            timeLeft_q  <= TIME_W'(GAME_SECONDS);
            startPrev_q <= 1'b0;
            redPix_q    <= '0;
            grnPix_q    <= '0;
        end else begin
            startPrev_q <= bus.start;
            redPix_q    <= redPix_d;
            grnPix_q    <= grnPix_d;
            case (state_q)
                IDLE: begin
                    if (bus.clear_high) begin
                        highScore_q <= '0;
                    end
                    if (startRise) begin
                        state_q     <= PLAY;
                        noteStore_q <= '0;
                        score_q     <= '0;
                        combo_q     <= '0;
                        timeLeft_q  <= TIME_W'(GAME_SECONDS);
                    end
                end
                PLAY: begin
                    noteStore_q <= noteStore_d;
                    score_q     <= score_d;
                    combo_q     <= combo_d;
                    if (bus.tick_1s && (timeLeft_q != '0)) begin
                        timeLeft_q <= timeLeft_q - TIME_W'(1);
                        if (timeLeft_q == TIME_W'(1)) begin
                            state_q     <= OVER;
                            highScore_q <= (score_d > highScore_q) ? score_d : highScore_q;
                        end
                    end
                end
                OVER: begin
                    if (startRise) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.red_pixels = redPix_q;
    assign bus.grn_pixels = grnPix_q;
    assign bus.score      = score_q;
    assign bus.high_score = highScore_q;
    assign bus.combo      = combo_q;
    assign bus.time_left  = timeLeft_q;
    assign bus.game_state = state_q;
endmodule
